// File: rtl/sobel_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------------
// sobel_ctrl : frame sequencer feeding the Sobel 3x3 window and writing results.
// Optional SOBEL_CTRL_PERF_EN adds perf_cycles (busy-cycle counter). Rev 1.0
// ------------------------------------------------------------------------
module sobel_ctrl #(
   parameter int CALC_TIMEOUT = 64
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        start,
   input  logic [11:0] width,
   input  logic [11:0] length,
   input  logic [7:0]  initial_addr_r,
   input  logic [7:0]  initial_addr_w,
   output logic        rd_req,
   output logic [31:0] rd_addr,
   input  logic        rd_ack,
   input  logic [7:0]  rd_data,
   output logic        pix_valid,
   output logic [7:0]  pix_data,
   output logic        calc_start,
   input  logic        calc_done,
   input  logic [7:0]  calc_result,
   output logic        wr_req,
   output logic [31:0] wr_addr,
   output logic [7:0]  wr_data,
   input  logic        wr_ack,
   output logic        busy,
   output logic        done,
   output logic        err
`ifdef SOBEL_CTRL_PERF_EN
   ,
   output logic [31:0] perf_cycles
`endif
);

   localparam int TW = $clog2(CALC_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_PUSH  = 3'd2,
      S_CALC  = 3'd3,
      S_WRITE = 3'd4,
      S_NEXT  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [11:0]   width_q, width_d;
   logic [11:0]   length_q, length_d;
   logic [7:0]    base_r_q, base_r_d;
   logic [7:0]    base_w_q, base_w_d;
   logic [11:0]   x_q, x_d;
   logic [11:0]   y_q, y_d;
   logic [11:0]   col_q, col_d;
   logic [1:0]    roff_q, roff_d;
   logic [3:0]    reads_left_q, reads_left_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    pix_q, pix_d;
   logic [7:0]    res_q, res_d;
   logic          err_q, err_d;

   logic [11:0]   rd_row;
   logic [23:0]   rd_prod, rd_off;
   logic [11:0]   wr_row;
   logic [23:0]   wr_prod, wr_off;

   // Bases have zero low 24 bits, so base + offset is a plain concatenation.
   assign rd_row  = y_q - 12'd1 + {10'd0, roff_q};
   assign rd_prod = {12'd0, rd_row} * {12'd0, width_q};
   assign rd_off  = rd_prod + {12'd0, col_q};
   assign wr_row  = y_q - 12'd1;
   assign wr_prod = {12'd0, wr_row} * {12'd0, width_q - 12'd2};
   assign wr_off  = wr_prod + {12'd0, x_q - 12'd1};

   always_comb begin
      state_d      = state_q;
      width_d      = width_q;
      length_d     = length_q;
      base_r_d     = base_r_q;
      base_w_d     = base_w_q;
      x_d          = x_q;
      y_d          = y_q;
      col_d        = col_q;
      roff_d       = roff_q;
      reads_left_d = reads_left_q;
      tmo_d        = tmo_q;
      pix_d        = pix_q;
      res_d        = res_q;
      err_d        = err_q;
      rd_req       = 1'b0;
      wr_req       = 1'b0;
      pix_valid    = 1'b0;
      calc_start   = 1'b0;
      done         = 1'b0;
      busy         = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               width_d  = width;
               length_d = length;
               base_r_d = initial_addr_r;
               base_w_d = initial_addr_w;
               err_d    = 1'b0;
               if (width < 12'd3 || length < 12'd3) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  x_d          = 12'd1;
                  y_d          = 12'd1;
                  col_d        = 12'd0;
                  roff_d       = 2'd0;
                  reads_left_d = 4'd9;
                  state_d      = S_READ;
               end
            end
         end
         S_READ: begin
            rd_req = 1'b1;
            if (rd_ack) begin
               pix_d        = rd_data;
               reads_left_d = reads_left_q - 4'd1;
               // Column-major walk: three rows per column, then step column.
               if (roff_q == 2'd2) begin
                  roff_d = 2'd0;
                  col_d  = col_q + 12'd1;
               end else begin
                  roff_d = roff_q + 2'd1;
               end
               state_d = S_PUSH;
            end
         end
         S_PUSH: begin
            pix_valid = 1'b1;
            if (reads_left_q == 4'd0) begin
               tmo_d   = '0;
               state_d = S_CALC;
            end else begin
               state_d = S_READ;
            end
         end
         S_CALC: begin
            calc_start = (tmo_q == '0);
            if (calc_done) begin
               res_d   = calc_result;
               state_d = S_WRITE;
            end else if (tmo_q == TW'(CALC_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_WRITE: begin
            wr_req = 1'b1;
            if (wr_ack) begin
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (x_q < width_q - 12'd2) begin
               x_d          = x_q + 12'd1;
               col_d        = x_q + 12'd2;
               roff_d       = 2'd0;
               reads_left_d = 4'd3;
               state_d      = S_READ;
            end else if (y_q < length_q - 12'd2) begin
               x_d          = 12'd1;
               y_d          = y_q + 12'd1;
               col_d        = 12'd0;
               roff_d       = 2'd0;
               reads_left_d = 4'd9;
               state_d      = S_READ;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Data outputs are gated so nothing stale is visible outside a handshake.
   assign rd_addr  = rd_req    ? {base_r_q, rd_off} : 32'h0;
   assign wr_addr  = wr_req    ? {base_w_q, wr_off} : 32'h0;
   assign wr_data  = wr_req    ? res_q : 8'h0;
   assign pix_data = pix_valid ? pix_q : 8'h0;
   assign err      = err_q;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q      <= S_IDLE;
         width_q      <= '0;
         length_q     <= '0;
         base_r_q     <= '0;
         base_w_q     <= '0;
         x_q          <= '0;
         y_q          <= '0;
         col_q        <= '0;
         roff_q       <= '0;
         reads_left_q <= '0;
         tmo_q        <= '0;
         pix_q        <= '0;
         res_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         width_q      <= width_d;
         length_q     <= length_d;
         base_r_q     <= base_r_d;
         base_w_q     <= base_w_d;
         x_q          <= x_d;
         y_q          <= y_d;
         col_q        <= col_d;
         roff_q       <= roff_d;
         reads_left_q <= reads_left_d;
         tmo_q        <= tmo_d;
         pix_q        <= pix_d;
         res_q        <= res_d;
         err_q        <= err_d;
      end
   end

`ifdef SOBEL_CTRL_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (state_q == S_IDLE && start) begin
         perf_d = 32'h0;
      end else if (busy && perf_q != 32'hFFFF_FFFF) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         perf_q <= 32'h0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_cycles = perf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sobel_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------------
// tb_sobel_ctrl : randomized scoreboard bench for sobel_ctrl. Rev 1.0
// ------------------------------------------------------------------------
module tb_sobel_ctrl;

   localparam int CALC_TIMEOUT = 64;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        start = 1'b0;
   logic [11:0] width = '0;
   logic [11:0] length = '0;
   logic [7:0]  initial_addr_r = '0;
   logic [7:0]  initial_addr_w = '0;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic        rd_ack = 1'b0;
   logic [7:0]  rd_data = '0;
   logic        pix_valid;
   logic [7:0]  pix_data;
   logic        calc_start;
   logic        calc_done = 1'b0;
   logic [7:0]  calc_result = '0;
   logic        wr_req;
   logic [31:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_ack = 1'b0;
   logic        busy;
   logic        done;
   logic        err;
`ifdef SOBEL_CTRL_PERF_EN
   logic [31:0] perf_cycles;
`endif

   sobel_ctrl #(.CALC_TIMEOUT(CALC_TIMEOUT)) dut (
      .HCLK           (HCLK),
      .HRESET         (HRESET),
      .start          (start),
      .width          (width),
      .length         (length),
      .initial_addr_r (initial_addr_r),
      .initial_addr_w (initial_addr_w),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_ack         (rd_ack),
      .rd_data        (rd_data),
      .pix_valid      (pix_valid),
      .pix_data       (pix_data),
      .calc_start     (calc_start),
      .calc_done      (calc_done),
      .calc_result    (calc_result),
      .wr_req         (wr_req),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_ack         (wr_ack),
      .busy           (busy),
      .done           (done),
      .err            (err)
`ifdef SOBEL_CTRL_PERF_EN
      ,
      .perf_cycles    (perf_cycles)
`endif
   );

   always #5 HCLK = ~HCLK;

   int cyc = 0;
   always @(posedge HCLK) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   logic [31:0] exp_rd[$];
   logic [7:0]  exp_pix[$];
   logic [31:0] exp_wa[$];
   logic [7:0]  exp_wd[$];
   logic        exp_err[$];

   int   rd_lo = 0, rd_hi = 0, wr_lo = 0, wr_hi = 0;
   bit   calc_hang = 1'b0;
   bit   strays = 1'b0;
   logic [7:0] salt = 8'h5A;

   int rd_cnt = 0, wr_cnt = 0, pix_cnt = 0, done_cnt = 0, busy_cnt = 0;
   int cs_cyc = 0, done_cyc = 0, st_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic nope(input string name, input logic [31:0] act);
      total++;
      bad++;
      $display("FAIL %s: got 0x%0h expected nothing (t=%0t)", name, act, $time);
   endtask

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ {a[3:0], a[7:4]} ^ a[31:24] ^ salt;
   endfunction

   // Reference: output pixel order, window read order and addresses from the image geometry.
   task automatic build_expect(input int w, input int l, input logic [7:0] br,
                               input logic [7:0] bw, input bit first_only);
      int nx, ny;
      logic [31:0] a;
      nx = first_only ? 1 : w - 2;
      ny = first_only ? 1 : l - 2;
      for (int y = 1; y <= ny; y++) begin
         for (int x = 1; x <= nx; x++) begin
            for (int c = ((x == 1) ? 0 : x + 1); c <= x + 1; c++) begin
               for (int r = y - 1; r <= y + 1; r++) begin
                  a = {br, 24'h0} + 32'(r * w + c);
                  exp_rd.push_back(a);
                  exp_pix.push_back(mem_byte(a));
               end
            end
            if (!first_only) exp_wa.push_back({bw, 24'h0} + 32'((y - 1) * (w - 2) + (x - 1)));
         end
      end
   endtask

   task automatic clear_queues();
      exp_rd.delete();
      exp_pix.delete();
      exp_wa.delete();
      exp_wd.delete();
      exp_err.delete();
   endtask

   // Read memory model
   initial begin
      int wt;
      wt = -1;
      forever begin
         @(negedge HCLK);
         rd_ack = 1'b0;
         if (HRESET) begin
            wt = -1;
         end else if (rd_req) begin
            if (wt < 0) wt = int'($urandom_range(rd_hi, rd_lo));
            if (wt == 0) begin
               rd_ack  = 1'b1;
               rd_data = mem_byte(rd_addr);
               wt      = -1;
            end else begin
               wt--;
            end
         end else begin
            wt = -1;
            if (strays && $urandom_range(3, 0) == 0) begin
               rd_ack  = 1'b1;
               rd_data = 8'($urandom);
            end
         end
      end
   end

   // Write memory model
   initial begin
      int wt;
      wt = -1;
      forever begin
         @(negedge HCLK);
         wr_ack = 1'b0;
         if (HRESET) begin
            wt = -1;
         end else if (wr_req) begin
            if (wt < 0) wt = int'($urandom_range(wr_hi, wr_lo));
            if (wt == 0) begin
               wr_ack = 1'b1;
               wt     = -1;
            end else begin
               wt--;
            end
         end else begin
            wt = -1;
            if (strays && $urandom_range(3, 0) == 0) wr_ack = 1'b1;
         end
      end
   end

   // Gradient engine model: random result; each issued result becomes an expected write datum.
   initial begin
      int wt;
      wt = -1;
      forever begin
         @(negedge HCLK);
         calc_done = 1'b0;
         if (HRESET) begin
            wt = -1;
         end else begin
            if (calc_start && !calc_hang) wt = int'($urandom_range(3, 0));
            if (wt == 0) begin
               calc_result = 8'($urandom);
               calc_done   = 1'b1;
               exp_wd.push_back(calc_result);
               wt = -1;
            end else if (wt > 0) begin
               wt--;
            end
         end
      end
   end

   // Monitor
   logic        p_rq = 1'b0, p_ra = 1'b0, p_wq = 1'b0, p_wa = 1'b0;
   logic [31:0] p_raddr = '0, p_waddr = '0;
   logic [7:0]  p_wdata = '0;

   initial begin
      forever begin
         @(negedge HCLK);
         #3;
         if (HRESET) begin
            p_rq = 1'b0;
            p_wq = 1'b0;
         end else begin
            if (busy) busy_cnt++;
            if (rd_req && p_rq && !p_ra) chk("rd_addr_hold", rd_addr, p_raddr);
            if (wr_req && p_wq && !p_wa) begin
               chk("wr_addr_hold", wr_addr, p_waddr);
               chk("wr_data_hold", {24'h0, wr_data}, {24'h0, p_wdata});
            end
            if (rd_req && rd_ack) begin
               rd_cnt++;
               if (exp_rd.size() == 0) nope("rd_unexpected", rd_addr);
               else chk("rd_addr", rd_addr, exp_rd.pop_front());
            end
            if (pix_valid) begin
               pix_cnt++;
               if (exp_pix.size() == 0) nope("pix_unexpected", {24'h0, pix_data});
               else chk("pix_data", {24'h0, pix_data}, {24'h0, exp_pix.pop_front()});
            end
            if (calc_start) cs_cyc = cyc;
            if (wr_req && wr_ack) begin
               wr_cnt++;
               if (exp_wa.size() == 0 || exp_wd.size() == 0) begin
                  nope("wr_unexpected", wr_addr);
               end else begin
                  chk("wr_addr", wr_addr, exp_wa.pop_front());
                  chk("wr_data", {24'h0, wr_data}, {24'h0, exp_wd.pop_front()});
               end
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
               if (exp_err.size() == 0) nope("done_unexpected", {31'h0, err});
               else chk("err_at_done", {31'h0, err}, {31'h0, exp_err.pop_front()});
            end
            p_rq = rd_req; p_ra = rd_ack; p_raddr = rd_addr;
            p_wq = wr_req; p_wa = wr_ack; p_waddr = wr_addr; p_wdata = wr_data;
         end
      end
   end

   task automatic kick(input int w, input int l, input logic [7:0] br, input logic [7:0] bw);
      @(negedge HCLK);
      width          = 12'(w);
      length         = 12'(l);
      initial_addr_r = br;
      initial_addr_w = bw;
      start          = 1'b1;
      st_cyc         = cyc;
      @(negedge HCLK);
      start          = 1'b0;
      width          = 12'($urandom);
      length         = 12'($urandom);
      initial_addr_r = 8'($urandom);
      initial_addr_w = 8'($urandom);
      #3;
      chk("busy_after_start", {31'h0, busy}, 32'h1);
      chk("rd_req_after_start", {31'h0, rd_req}, (w >= 3 && l >= 3) ? 32'h1 : 32'h0);
   endtask

   task automatic run_frame(input int w, input int l, input logic [7:0] br, input logic [7:0] bw,
                            input int rlo, input int rhi, input int wlo, input int whi,
                            input bit hang, input bit st, input bit poke);
      int n_rd, n_wr;
      bit err_frame;
      rd_lo = rlo; rd_hi = rhi; wr_lo = wlo; wr_hi = whi;
      calc_hang = hang;
      strays    = st;
      salt      = 8'($urandom);
      clear_queues();
      err_frame = (w < 3 || l < 3);
      if (!err_frame) build_expect(w, l, br, bw, hang);
      exp_err.push_back(err_frame || hang);
      n_rd = exp_rd.size();
      n_wr = exp_wa.size();
      rd_cnt = 0; wr_cnt = 0; pix_cnt = 0; done_cnt = 0; busy_cnt = 0;
      kick(w, l, br, bw);
      for (int n = 0; n < 20000 && done_cnt == 0; n++) begin
         @(negedge HCLK);
         start = (poke && n == 10 && busy) ? 1'b1 : 1'b0;
      end
      start = 1'b0;
      if (done_cnt == 0) nope("done_timeout", 32'(cyc));
      #3;
      chk("busy_after_done", {31'h0, busy}, 32'h0);
      chk("done_count", 32'(done_cnt), 32'h1);
      chk("rd_count", 32'(rd_cnt), 32'(n_rd));
      chk("pix_count", 32'(pix_cnt), 32'(n_rd));
      chk("wr_count", 32'(wr_cnt), 32'(n_wr));
      chk("rd_left", 32'(exp_rd.size()), 32'h0);
      chk("wr_left", 32'(exp_wa.size()), 32'h0);
      if (err_frame) chk("err_done_latency", 32'(done_cyc - st_cyc <= 2), 32'h1);
      if (hang) chk("calc_timeout_cycles", 32'(done_cyc - cs_cyc), 32'(CALC_TIMEOUT));
`ifdef SOBEL_CTRL_PERF_EN
      chk("perf_cycles", perf_cycles, 32'(busy_cnt));
`endif
      strays = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge HCLK);
      #3;
      chk("rst_rd_req", {31'h0, rd_req}, 32'h0);
      chk("rst_wr_req", {31'h0, wr_req}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      chk("rst_rd_addr", rd_addr, 32'h0);
`ifdef SOBEL_CTRL_PERF_EN
      chk("rst_perf", perf_cycles, 32'h0);
`endif
      @(negedge HCLK);
      HRESET = 1'b0;

      run_frame(4, 4, 8'h10, 8'h20, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      run_frame(4, 4, 8'h10, 8'h20, 5, 5, 3, 3, 1'b0, 1'b0, 1'b0);
      run_frame(2, 10, 8'h10, 8'h20, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      run_frame(5, 2, 8'h33, 8'h44, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      run_frame(4, 4, 8'h10, 8'h20, 0, 1, 0, 1, 1'b1, 1'b0, 1'b0);
      run_frame(3, 3, 8'hFE, 8'h01, 0, 2, 0, 2, 1'b0, 1'b0, 1'b1);

      // Abort during WRITE
      rd_lo = 0; rd_hi = 0; wr_lo = 3; wr_hi = 3;
      calc_hang = 1'b0;
      clear_queues();
      build_expect(4, 4, 8'h10, 8'h20, 1'b0);
      done_cnt = 0;
      kick(4, 4, 8'h10, 8'h20);
      for (int n = 0; n < 500 && !wr_req; n++) begin
         @(negedge HCLK);
         #3;
      end
      chk("reached_write", {31'h0, wr_req}, 32'h1);
      #1 HRESET = 1'b1;
      #1;
      chk("abort_wr_req", {31'h0, wr_req}, 32'h0);
      chk("abort_rd_req", {31'h0, rd_req}, 32'h0);
      chk("abort_wr_addr", wr_addr, 32'h0);
      chk("abort_wr_data", {24'h0, wr_data}, 32'h0);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_misc", {28'h0, done, pix_valid, calc_start, err}, 32'h0);
      repeat (3) @(negedge HCLK);
      clear_queues();
      HRESET = 1'b0;
      repeat (5) @(negedge HCLK);
      chk("abort_no_done", 32'(done_cnt), 32'h0);

      run_frame(4, 4, 8'h10, 8'h20, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         run_frame(int'($urandom_range(7, 3)), int'($urandom_range(6, 3)),
                   8'($urandom), 8'($urandom), 0, 3, 0, 3, 1'b0, 1'b1, 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
